// File: rtl/ram_rd_sched_pkg.sv
// Shared types and sizing helpers for the cache read-burst scheduler.
package rd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    function automatic int num_req(input int log2n);
        return 1 << log2n;
    endfunction

    function automatic int fifo_depth(input int log2d);
        return 1 << log2d;
    endfunction

endpackage

// File: rtl/ram_rd_sched_rr_arb.sv
// N-way round-robin arbiter: first asserted request at or after ptr wins.
module rd_sched_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] j;

    // N is a power of two, so ptr + i wraps for free
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int i = 0; i < N; i++) begin
            j = ptr + IW'(i);
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = j;
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_rd_sched.sv
// Cache read-burst scheduler: round-robin grant gated by FIFO room, one burst in flight.
// Optional data-phase watchdog enabled by defining RD_SCHED_TIMEOUT_EN.
import rd_sched_pkg::*;

module ram_rd_sched #(
    parameter int RAM_AW           = 8,
    parameter int FIFO_NUM_OBLK    = 2,
    parameter int FIFO_DEPTH_WIDTH = 4,
    parameter int TIMEOUT_CYC      = 1024
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [(2**FIFO_NUM_OBLK)-1:0]                    req_valid,
    output logic [(2**FIFO_NUM_OBLK)-1:0]                    req_ready,
    input  logic [(2**FIFO_NUM_OBLK)*RAM_AW-1:0]             req_addr,
    input  logic [(2**FIFO_NUM_OBLK)*RAM_AW-1:0]             req_len,
    input  logic [(2**FIFO_NUM_OBLK)*(FIFO_DEPTH_WIDTH+1)-1:0] fifo_count,
    output logic                                             ren,
    output logic [RAM_AW-1:0]                                raddr,
    output logic [RAM_AW-1:0]                                rlength,
    input  logic                                             dvalid,
    input  logic                                             dlast,
    output logic [(2**FIFO_NUM_OBLK)-1:0]                    wr_sel,
    output logic                                             busy,
    output logic                                             len_err,
    output logic                                             timeout
);

    localparam int N  = num_req(FIFO_NUM_OBLK);
    localparam int IW = FIFO_NUM_OBLK;
    localparam int CW = FIFO_DEPTH_WIDTH + 1;
    localparam int LW = RAM_AW + 1;
    localparam logic [LW-1:0] DEPTH = LW'(fifo_depth(FIFO_DEPTH_WIDTH));

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, g_q;
    logic [RAM_AW-1:0] addr_q, len_q, beat_q;
    logic              len_err_q;
    logic              to_hit;

    logic [N-1:0]      eligible, arb_gnt, gsel;
    logic [IW-1:0]     arb_idx;
    logic              arb_any, zlen;
    logic [RAM_AW-1:0] addr_a [N];
    logic [RAM_AW-1:0] len_a  [N];

    // A burst is only eligible if the whole thing fits in the destination FIFO
    for (genvar i = 0; i < N; i++) begin : g_elig
        logic [LW-1:0] room;
        assign addr_a[i]   = req_addr[i*RAM_AW +: RAM_AW];
        assign len_a[i]    = req_len[i*RAM_AW +: RAM_AW];
        assign room        = DEPTH - LW'(fifo_count[i*CW +: CW]);
        assign eligible[i] = req_valid[i] & ({1'b0, len_a[i]} <= room);
    end

    rd_sched_rr_arb #(.N(N), .IW(IW)) u_arb (
        .req (eligible),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign zlen = arb_any && (len_a[arb_idx] == '0);
    assign gsel = N'(1) << g_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_any && !zlen) state_d = ISSUE;
            ISSUE:   state_d = DATA;
            DATA:    if ((dvalid && dlast) || to_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ren       = 1'b0;
        raddr     = '0;
        rlength   = '0;
        req_ready = '0;
        wr_sel    = '0;
        unique case (state_q)
            IDLE:    if (zlen && !rst) req_ready = arb_gnt;
            ISSUE: begin
                ren       = 1'b1;
                raddr     = addr_q;
                rlength   = len_q;
                req_ready = gsel;
                wr_sel    = gsel;
            end
            DATA:    wr_sel = gsel;
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign len_err = len_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            g_q       <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (zlen) begin
                        ptr_q <= arb_idx + 1'b1;
                    end else if (arb_any) begin
                        g_q    <= arb_idx;
                        addr_q <= addr_a[arb_idx];
                        len_q  <= len_a[arb_idx];
                    end
                end
                ISSUE: begin
                    ptr_q  <= g_q + 1'b1;
                    beat_q <= '0;
                end
                DATA: begin
                    if (dvalid) begin
                        beat_q <= beat_q + 1'b1;
                        if (dlast) len_err_q <= ((beat_q + 1'b1) != len_q);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RD_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] to_cnt;
    logic          to_q;

    assign to_hit  = (state_q == DATA) && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign timeout = to_q;

    // dlast on the limit cycle still completes the burst normally
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            to_cnt <= (state_q == DATA) ? to_cnt + 1'b1 : '0;
            to_q   <= to_hit && !(dvalid && dlast);
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ram_rd_sched.sv
// Self-checking bench for ram_rd_sched: vector table, corner sequences, randomized model check.
module tb_ram_rd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, wr_sel;
    logic [31:0] req_addr, req_len;
    logic [19:0] fifo_count;
    logic        ren, dvalid, dlast, busy, len_err, timeout;
    logic [7:0]  raddr, rlength;

    ram_rd_sched #(.RAM_AW(8), .FIFO_NUM_OBLK(2), .FIFO_DEPTH_WIDTH(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .fifo_count(fifo_count),
        .ren(ren), .raddr(raddr), .rlength(rlength), .dvalid(dvalid), .dlast(dlast),
        .wr_sel(wr_sel), .busy(busy), .len_err(len_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int last_ren = -100;

    typedef struct {
        logic [3:0]      rv;
        logic [3:0][7:0] len;
        logic [3:0][4:0] cnt;
        int              exp_idx;
        int              beats;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // ren-to-ren spacing must be at least three cycles
    always @(negedge clk) begin
        if (ren === 1'b1) begin
            nvec++;
            if (cyc - last_ren < 3) begin
                nerr++;
                $display("FAIL ren_spacing: got %0d cycles expected >= 3", cyc - last_ren);
            end
            last_ren = cyc;
        end
    end

    task automatic wait_ren(input string nm, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ren === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({nm, " ren_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic do_burst(input string nm, input int ei, input logic [7:0] ea,
                            input logic [7:0] el, input int beats, input bit gaps);
        bit seen;
        wait_ren(nm, seen);
        if (!seen) begin
            req_valid = '0;
            return;
        end
        chk({nm, " raddr"},     32'(raddr),     32'(ea));
        chk({nm, " rlength"},   32'(rlength),   32'(el));
        chk({nm, " req_ready"}, 32'(req_ready), 32'(4'b1 << ei));
        chk({nm, " wr_sel"},    32'(wr_sel),    32'(4'b1 << ei));
        req_valid = '0;
        @(negedge clk);
        chk({nm, " data_ren"},    32'(ren),    32'd0);
        chk({nm, " data_wr_sel"}, 32'(wr_sel), 32'(4'b1 << ei));
        for (int b = 1; b <= beats; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                dvalid = 1'b0;
                dlast  = 1'b0;
                @(negedge clk);
            end
            dvalid = 1'b1;
            dlast  = (b == beats);
            @(negedge clk);
        end
        dvalid = 1'b0;
        dlast  = 1'b0;
        chk({nm, " end_wr_sel"}, 32'(wr_sel),  32'd0);
        chk({nm, " end_busy"},   32'(busy),    32'd0);
        chk({nm, " len_err"},    32'(len_err), 32'(beats != int'(el)));
        chk({nm, " timeout"},    32'(timeout), 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " ren"},       32'(ren),       32'd0);
        chk({nm, " raddr"},     32'(raddr),     32'd0);
        chk({nm, " rlength"},   32'(rlength),   32'd0);
        chk({nm, " req_ready"}, 32'(req_ready), 32'd0);
        chk({nm, " wr_sel"},    32'(wr_sel),    32'd0);
        chk({nm, " busy"},      32'(busy),      32'd0);
        chk({nm, " len_err"},   32'(len_err),   32'd0);
        chk({nm, " timeout"},   32'(timeout),   32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][7:0] la, aa;
        logic [3:0][4:0] ca;
        logic [3:0]      rv;
        int              mptr, k, beats;
        bit              seen;

        tv[0]  = '{rv: 4'b1111, len: {8'd4, 8'd4, 8'd4, 8'd4}, cnt: '0, exp_idx: 0, beats: 4};
        tv[1]  = '{rv: 4'b1111, len: {8'd4, 8'd4, 8'd4, 8'd4}, cnt: '0, exp_idx: 1, beats: 4};
        tv[2]  = '{rv: 4'b1111, len: {8'd4, 8'd4, 8'd4, 8'd4}, cnt: '0, exp_idx: 2, beats: 4};
        tv[3]  = '{rv: 4'b1111, len: {8'd4, 8'd4, 8'd4, 8'd4}, cnt: '0, exp_idx: 3, beats: 4};
        tv[4]  = '{rv: 4'b1111, len: {8'd4, 8'd4, 8'd4, 8'd4}, cnt: '0, exp_idx: 0, beats: 4};
        tv[5]  = '{rv: 4'b0110, len: {8'd0, 8'd4, 8'd10, 8'd0}, cnt: {5'd0, 5'd0, 5'd8, 5'd0}, exp_idx: 2, beats: 4};
        tv[6]  = '{rv: 4'b0010, len: {8'd0, 8'd0, 8'd10, 8'd0}, cnt: {5'd0, 5'd0, 5'd6, 5'd0}, exp_idx: 1, beats: 10};
        tv[7]  = '{rv: 4'b0001, len: {8'd0, 8'd0, 8'd0, 8'd16}, cnt: '0, exp_idx: 0, beats: 16};
        tv[8]  = '{rv: 4'b0100, len: {8'd0, 8'd5, 8'd0, 8'd0}, cnt: '0, exp_idx: 2, beats: 3};
        tv[9]  = '{rv: 4'b1000, len: {8'd1, 8'd0, 8'd0, 8'd0}, cnt: {5'd15, 5'd0, 5'd0, 5'd0}, exp_idx: 3, beats: 1};
        tv[10] = '{rv: 4'b1010, len: {8'd3, 8'd0, 8'd2, 8'd0}, cnt: {5'd13, 5'd0, 5'd15, 5'd0}, exp_idx: 3, beats: 3};

        rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0; fifo_count = '0;
        dvalid = 1'b0; dlast = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Vector table: pointer history is folded into each expected grant
        for (int v = 0; v < 11; v++) begin
            for (int i = 0; i < 4; i++) aa[i] = 8'(16 * i + v);
            req_addr = aa; req_len = tv[v].len; fifo_count = tv[v].cnt; req_valid = tv[v].rv;
            do_burst($sformatf("vec%0d", v), tv[v].exp_idx, aa[tv[v].exp_idx],
                     tv[v].len[tv[v].exp_idx], tv[v].beats, 1'b0);
        end

        // Zero-length request: ready pulse without a read, pointer 0 -> 1
        aa = {8'h33, 8'h22, 8'h11, 8'h00};
        req_addr = aa; req_len = '0; fifo_count = '0; req_valid = 4'b0001;
        #1;
        chk("zlen req_ready", 32'(req_ready), 32'h1);
        chk("zlen ren", 32'(ren), 32'd0);
        @(negedge clk);
        chk("zlen ren_after", 32'(ren), 32'd0);
        chk("zlen busy", 32'(busy), 32'd0);
        req_valid = '0;
        req_len = {8'd2, 8'd2, 8'd2, 8'd2}; req_valid = 4'b1011;
        do_burst("zlen_next", 1, aa[1], 8'd2, 2, 1'b0);

        // Reset in the middle of a data phase
        req_len = {8'd0, 8'd4, 8'd0, 8'd0}; req_valid = 4'b0100;
        wait_ren("rst_mid", seen);
        req_valid = '0;
        @(negedge clk);
        dvalid = 1'b1; dlast = 1'b0;
        @(negedge clk);
        dvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rst = 1'b0;
        req_len = {8'd1, 8'd1, 8'd1, 8'd1}; req_valid = 4'b1111;
        do_burst("after_rst", 0, aa[0], 8'd1, 1, 1'b0);
        mptr = 1;

`ifdef RD_SCHED_TIMEOUT_EN
        req_len = {8'd0, 8'd0, 8'd4, 8'd0}; req_valid = 4'b0010;
        wait_ren("tmo", seen);
        req_valid = '0;
        k = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                k = n;
                break;
            end
        end
        chk("tmo pulse_cycle", 32'(k), 32'd17);
        chk("tmo wr_sel", 32'(wr_sel), 32'd0);
        chk("tmo busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("tmo one_cycle", 32'(timeout), 32'd0);
        req_len = {8'd0, 8'd2, 8'd0, 8'd0}; req_valid = 4'b0100;
        do_burst("tmo_next", 2, aa[2], 8'd2, 2, 1'b0);
        mptr = 3;
`endif

        // Randomized traffic against a first-fit round-robin model
        for (int t = 0; t < 200; t++) begin
            rv = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                la[i] = 8'($urandom_range(0, 12));
                ca[i] = 5'($urandom_range(0, 16));
                aa[i] = 8'($urandom);
            end
            k = -1;
            for (int s = 0; s < 4; s++) begin
                int q;
                q = (mptr + s) % 4;
                if (k < 0 && rv[q] && int'(la[q]) <= 16 - int'(ca[q])) k = q;
            end
            req_addr = aa; req_len = la; fifo_count = ca; req_valid = rv;
            if (k < 0) begin
                #1;
                chk("rnd none req_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
                chk("rnd none ren", 32'(ren), 32'd0);
                chk("rnd none busy", 32'(busy), 32'd0);
                req_valid = '0;
            end else if (la[k] == 8'd0) begin
                #1;
                chk("rnd zlen req_ready", 32'(req_ready), 32'(4'b1 << k));
                @(negedge clk);
                chk("rnd zlen ren", 32'(ren), 32'd0);
                req_valid = '0;
                mptr = (k + 1) % 4;
            end else begin
                beats = ($urandom_range(0, 3) != 0) ? int'(la[k]) : int'($urandom_range(1, int'(la[k]) + 2));
                do_burst($sformatf("rnd%0d", t), k, aa[k], la[k], beats, 1'b1);
                mptr = (k + 1) % 4;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
